// File: rtl/alu8_pkg.sv
// Shared opcode encoding and default width for the alu8 datapath block.
package alu8_pkg;

   localparam int ALU8_W = 8;

   typedef enum logic [1:0] {
      OP_NOT = 2'd0,
      OP_OR  = 2'd1,
      OP_AND = 2'd2,
      OP_ADD = 2'd3
   } alu8_op_e;

endpackage

// File: rtl/alu8_rca.sv
// Combinational WIDTH-bit ripple-carry adder built from full-adder cells.
module alu8_rca #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
         assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = carry[WIDTH];

endmodule

// File: rtl/alu8.sv
// Four-function ALU (NOT/OR/AND/ADD) with one-cycle registered outputs.
// Define ALU8_FLAGS_EN to add the registered zero and signed-overflow flags.
module alu8
   import alu8_pkg::*;
#(
   parameter int WIDTH = ALU8_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       f,
   output logic [WIDTH-1:0] out,
`ifdef ALU8_FLAGS_EN
   output logic             zero,
   output logic             ovf,
`endif
   output logic             cout
);

   alu8_op_e         op;
   logic [WIDTH-1:0] sum;
   logic             add_cout;
   logic [WIDTH-1:0] res_next;
   logic             carry_next;
   logic [WIDTH-1:0] res_reg;
   logic             carry_reg;

   assign op = alu8_op_e'(f);

   alu8_rca #(
      .WIDTH(WIDTH)
   ) u_rca (
      .a   (a),
      .b   (b),
      .cin (cin),
      .sum (sum),
      .cout(add_cout)
   );

   always_comb begin
      res_next   = '0;
      carry_next = 1'b0;
      case (op)
         OP_NOT:  res_next = ~a;
         OP_OR:   res_next = a | b;
         OP_AND:  res_next = a & b;
         default: begin
            res_next   = sum;
            carry_next = add_cout;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_reg   <= '0;
         carry_reg <= 1'b0;
      end else begin
         res_reg   <= res_next;
         carry_reg <= carry_next;
      end
   end

   assign out  = res_reg;
   assign cout = carry_reg;

`ifdef ALU8_FLAGS_EN
   logic zero_next;
   logic ovf_next;
   logic zero_reg;
   logic ovf_reg;

   // Overflow only has meaning for the adder path; logic ops always report 0.
   assign zero_next = (res_next == '0);
   assign ovf_next  = (op == OP_ADD) && (a[WIDTH-1] == b[WIDTH-1]) &&
                      (sum[WIDTH-1] != a[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else begin
         zero_reg <= zero_next;
         ovf_reg  <= ovf_next;
      end
   end

   assign zero = zero_reg;
   assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed cases, reset behaviour and random
// regression against an integer-arithmetic reference model.
module tb_alu8;
   import alu8_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cin;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] f;
   logic [7:0] out;
   logic       cout;
`ifdef ALU8_FLAGS_EN
   logic       zero;
   logic       ovf;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   alu8 #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .cin  (cin),
      .a    (a),
      .b    (b),
      .f    (f),
      .out  (out),
`ifdef ALU8_FLAGS_EN
      .zero (zero),
      .ovf  (ovf),
`endif
      .cout (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: plain integer arithmetic, signed overflow judged by range.
   function automatic void model(input int fo, input int ai, input int bi, input int ci,
                                 output int r, output int co, output int z, output int ov);
      int s;
      int sa;
      int sb;
      co = 0;
      ov = 0;
      case (fo)
         0: r = 255 - ai;
         1: r = ai | bi;
         2: r = ai & bi;
         default: begin
            s  = ai + bi + ci;
            r  = s % 256;
            co = s / 256;
            sa = (ai > 127) ? ai - 256 : ai;
            sb = (bi > 127) ? bi - 256 : bi;
            s  = sa + sb + ci;
            ov = (s > 127 || s < -128) ? 1 : 0;
         end
      endcase
      z = (r == 0) ? 1 : 0;
   endfunction

   // eo/ec: extra hard-coded expectations for directed cases, -1 to skip.
   task automatic run_op(input string tag, input int fo, input int ai, input int bi,
                         input int ci, input int eo, input int ec);
      int r, co, z, ov;
      @(negedge clk);
      f   = fo[1:0];
      a   = ai[7:0];
      b   = bi[7:0];
      cin = ci[0];
      model(fo, ai, bi, ci, r, co, z, ov);
      @(posedge clk);
      #1;
      $display("%s f=%0d a=%02h b=%02h cin=%0d -> out=%02h cout=%0d",
               tag, fo, ai, bi, ci, out, cout);
      check({tag, ".out"}, int'(out), r);
      check({tag, ".cout"}, int'(cout), co);
      if (eo >= 0) check({tag, ".out_k"}, int'(out), eo);
      if (ec >= 0) check({tag, ".cout_k"}, int'(cout), ec);
`ifdef ALU8_FLAGS_EN
      check({tag, ".zero"}, int'(zero), z);
      check({tag, ".ovf"}, int'(ovf), ov);
`endif
   endtask

   initial begin
      f = 2'd0; a = 8'h00; b = 8'h00; cin = 1'b0;

      // Reset with no clock edge involved, then held across edges.
      #2 rst_n = 1'b0;
      #1;
      $display("reset asserted -> out=%02h cout=%0d", out, cout);
      check("rst.out", int'(out), 0);
      check("rst.cout", int'(cout), 0);
      f = 2'd3; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      $display("reset held -> out=%02h cout=%0d", out, cout);
      check("rst_hold.out", int'(out), 0);
      check("rst_hold.cout", int'(cout), 0);
      @(negedge clk) rst_n = 1'b1;

      run_op("not",      0, 'h3C, 'hFF, 1, 'hC3, 0);
      run_op("or",       1, 'h81, 'h18, 0, 'h99, 0);
      run_op("and",      2, 'hF0, 'h3C, 1, 'h30, 0);
      run_op("add_c",    3, 'hFF, 'h01, 1, 'h01, 1);
      run_op("add_nc",   3, 'h12, 'h34, 0, 'h46, 0);
      run_op("add_wrap", 3, 'hFF, 'h00, 1, 'h00, 1);
      run_op("add_zero", 3, 'h00, 'h00, 0, 'h00, 0);
      run_op("add_neg",  3, 'h80, 'h80, 0, 'h00, 1);
      run_op("add_pos",  3, 'h7F, 'h00, 1, 'h80, 0);

      // Mid-stream reset discards the in-flight ADD, release between edges.
      run_op("pre_rst",  1, 'h81, 'h18, 0, 'h99, 0);
      @(negedge clk);
      f = 2'd3; a = 8'h12; b = 8'h34; cin = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      $display("mid reset -> out=%02h cout=%0d", out, cout);
      check("mid_rst.out", int'(out), 0);
      check("mid_rst.cout", int'(cout), 0);
      @(posedge clk);
      #1;
      check("mid_rst_edge.out", int'(out), 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("after release -> out=%02h cout=%0d", out, cout);
      check("release.out", int'(out), 'h46);
      check("release.cout", int'(cout), 0);

      for (int op = 0; op < 4; op++) begin
         for (int i = 0; i < 30; i++) begin
            run_op($sformatf("rnd%0d_%0d", op, i), op, int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), -1,
                   (op == 3) ? -1 : 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
